wb_ddr_arbiter: RTL and testbench
=================================

// Module: wb_ddr_arbiter
// PURPOSE
//  2-master -> 1-slave Wishbone arbiter sharing the ddr0 slave port between two requesters
//  (e.g. the interconnect's ddr window and a DMA/video master). Round-robin, cycle-granular
//  grant held for the full CYC of the winner. 32-bit data, byte selects, classic WB cycles.
// PARAMETERS
//  adr_width       32    width of mN_adr_i / s_adr_o
//  timeout_cycles  1023  stall cycles before abort (only with WB_ARB_TIMEOUT_EN); 1..65535
// PORTS
//  clk_i          in   1          system clock
//  rst_ni         in   1          reset, synchronous, active-low
//  m0_/m1_adr_i   in   adr_width  master address
//  m0_/m1_dat_i   in   32         master write data
//  m0_/m1_dat_o   out  32         read data (both = s_dat_i)
//  m0_/m1_sel_i   in   4          byte selects
//  m0_/m1_we_i    in   1          write enable
//  m0_/m1_cyc_i   in   1          cycle request
//  m0_/m1_stb_i   in   1          strobe
//  m0_/m1_ack_o   out  1          ack, only to the granted master
//  m0_/m1_err_o   out  1          error, only to the granted master
//  s_adr_o/s_dat_o/s_sel_o/s_we_o  out  adr_width/32/4/1  muxed from granted master
//  s_cyc_o, s_stb_o  out  1       gated by grant
//  s_dat_i        in   32         slave read data
//  s_ack_i, s_err_i  in  1        slave termination
// BEHAVIOUR
//  - States: IDLE, GNT0, GNT1, ABORT (ABORT only with macro). Register last_gnt (1 bit).
//  - Reset (rst_ni=0 at clk edge): state=IDLE, last_gnt=1 (m0 wins first), timeout cnt=0.
//    Outputs then: s_cyc_o=s_stb_o=0, all mN_ack_o/err_o=0; s_adr/dat/sel/we = m0 inputs.
//  - IDLE: no grant, s_cyc_o=0. Request = mN_cyc_i. One request -> GNTn next edge.
//    Both -> grant the master != last_gnt. Arbitration latency: 1 clock from cyc to s_cyc_o.
//  - GNTn: s_* = mN_* combinationally; s_cyc_o=mN_cyc_i, s_stb_o=mN_stb_i;
//    mN_ack_o=s_ack_i, mN_err_o=s_err_i; other master ack/err=0. last_gnt<=n on entry.
//  - Release: when mN_cyc_i=0 in GNTn: if other master's cyc=1 -> GNT(other) next edge
//    (back-to-back, no IDLE bubble), else IDLE. Grant never preempted while cyc held,
//    including multi-strobe bursts. s_cyc_o drops in the same cycle mN_cyc_i drops.
//  - A master raising cyc while the other is granted waits; its stb is ignored, ack=0.
//  - Reset mid-transaction: cycle aborted, s_cyc_o=0 next cycle; no ack delivered.
//  - s_ack_i/s_err_i while IDLE are ignored (not forwarded).
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - 16-bit cnt increments each cycle with s_stb_o=1 & s_ack_i=0 & s_err_i=0; clears on
//     ack/err/grant change. When cnt == timeout_cycles-1 and still no ack: granted mN_err_o=1
//     for exactly that cycle, state->ABORT, s_cyc_o=s_stb_o=0 from next cycle.
//   - ABORT: slave deselected, late s_ack_i dropped; leaves to IDLE/other grant when
//     aborted master drops cyc (same rules as release).
//  Not defined: no counter, no ABORT state; stuck slave stalls the granted master forever.
// TESTING
//  1 m0 read only, s_ack_i at 3rd cycle of s_stb_o, s_dat_i=32'hDEADBEEF -> m0_ack_o 1 cycle,
//    m0_dat_o=DEADBEEF, m1_ack_o=0 throughout, s_cyc_o 1 cycle after m0_cyc_i.
//  2 after reset both cyc rise together, 1-cycle acks -> m0 served first; m1 granted on edge
//    after m0_cyc_i falls, no idle cycle between.
//  3 both hold requests for 4 single writes each (adr 0x40000000+4k) -> slave sees
//    m0,m1,m0,m1,... strict alternation, write data/sel matching the owner.
//  4 m1 burst of 4 strobes under one cyc, m0 requests mid-burst -> all 4 go to m1, m0_ack_o=0
//    until m1_cyc_i falls, then m0 granted.
//  5 rst_ni low for 1 cycle during m1 stalled read -> s_cyc_o=0 next cycle, no acks,
//    next simultaneous request granted to m0.
//  6 (WB_ARB_TIMEOUT_EN, timeout_cycles=8) m0 read, slave never acks -> m0_err_o=1 on 8th stall
//    cycle only, s_cyc_o=0 after; m1 request then granted once m0_cyc_i drops.

Source files
------------

// File: rtl/wb_ddr_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_ddr_arbiter_if
//
// Classic Wishbone link (32-bit data, 4 byte selects) used on the ports of
// wb_ddr_arbiter. A single link carries one master-to-slave connection.
//
// Parameters:
//   adr_width  width of adr
//
// Signals:
//   adr    master -> slave  address
//   dat_w  master -> slave  write data
//   sel    master -> slave  byte selects
//   we     master -> slave  write enable
//   cyc    master -> slave  cycle request
//   stb    master -> slave  strobe
//   dat_r  slave -> master  read data
//   ack    slave -> master  normal termination
//   err    slave -> master  error termination
//
// Modports:
//   master  the side that starts cycles (drives adr/dat_w/sel/we/cyc/stb)
//   slave   the side that terminates cycles (drives dat_r/ack/err)
// ----------------------------------------------------------------------------
interface wb_ddr_arbiter_if #(
    parameter int adr_width = 32
) ();

    logic [adr_width-1:0] adr;
    logic [31:0]          dat_w;
    logic [31:0]          dat_r;
    logic [3:0]           sel;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;
    logic                 err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_ddr_arbiter.sv
// ----------------------------------------------------------------------------
// wb_ddr_arbiter
//
// Two-master to one-slave Wishbone arbiter sharing the ddr0 slave port
// between two requesters (e.g. the interconnect ddr window and a DMA/video
// master). Round-robin, cycle-granular: the winner keeps the grant for its
// whole CYC, including multi-strobe bursts, and is never preempted.
//
// Parameters:
//   adr_width       address width of all three links
//   timeout_cycles  stall cycles before a cycle is aborted (1..65535),
//                   only effective with WB_ARB_TIMEOUT_EN
//
// Ports:
//   clk_i   in   system clock
//   rst_ni  in   synchronous active-low reset
//   m0      slave modport   link from requester 0
//   m1      slave modport   link from requester 1
//   s       master modport  link to the shared ddr0 slave
//
// Build option:
//   WB_ARB_TIMEOUT_EN  when defined, a stalled slave is abandoned after
//                      timeout_cycles stall cycles: the granted master gets a
//                      one-cycle err and the slave is deselected (ABORT)
//                      until that master drops cyc. When undefined, a stuck
//                      slave stalls the granted master indefinitely.
// ----------------------------------------------------------------------------
module wb_ddr_arbiter #(
    parameter int adr_width      = 32,
    parameter int timeout_cycles = 1023
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    wb_ddr_arbiter_if.slave  m0,
    wb_ddr_arbiter_if.slave  m1,
    wb_ddr_arbiter_if.master s
);

    if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_timeout
        $error("wb_ddr_arbiter: timeout_cycles must be within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
        ,
        ABORT = 2'd3
`endif
    } state_t;

    state_t               state_q;
    state_t               state_d;
    // 0: m0 held the most recent grant, 1: m1 did. Reset to 1 so m0 wins first.
    logic                 last_gnt;
    logic                 timeout_hit;
    logic [adr_width-1:0] adr_mux;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0]          stall_cnt_q;
    logic                 stall;

    assign stall       = s.stb && !s.ack && !s.err;
    assign timeout_hit = stall && (stall_cnt_q == 16'(timeout_cycles - 1));

    // Stall counter restarts on every termination and on every grant change,
    // so each granted cycle gets its own full timeout budget.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if ((state_d != state_q) || s.ack || s.err) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State and round-robin history. last_gnt follows whichever master is
    // being granted next, so it is updated on entry to GNT0/GNT1.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state_d == GNT1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    // Next-state logic. A release hands over directly to a waiting master
    // without passing through IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_gnt ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_d = GNT0;
                end else if (m1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc) begin
                    state_d = m1.cyc ? GNT1 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ABORT;
`endif
                end
            end
            GNT1: begin
                if (!m1.cyc) begin
                    state_d = m0.cyc ? GNT0 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ABORT;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            // last_gnt still names the aborted master here.
            ABORT: begin
                if (!last_gnt && !m0.cyc) begin
                    state_d = m1.cyc ? GNT1 : IDLE;
                end else if (last_gnt && !m1.cyc) begin
                    state_d = m0.cyc ? GNT0 : IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Slave-side address/data path follows m1 only while m1 is granted;
    // otherwise m0 is presented (including IDLE and reset).
    always_comb begin
        adr_mux = m0.adr;
        s.dat_w = m0.dat_w;
        s.sel   = m0.sel;
        s.we    = m0.we;
        if (state_q == GNT1) begin
            adr_mux = m1.adr;
            s.dat_w = m1.dat_w;
            s.sel   = m1.sel;
            s.we    = m1.we;
        end
    end

    assign s.adr = adr_mux;

    // Cycle/strobe pass through only for the granted master, so s.cyc drops
    // in the same cycle the owner drops its cyc.
    always_comb begin
        s.cyc = 1'b0;
        s.stb = 1'b0;
        case (state_q)
            GNT0: begin
                s.cyc = m0.cyc;
                s.stb = m0.stb;
            end
            GNT1: begin
                s.cyc = m1.cyc;
                s.stb = m1.stb;
            end
            default: begin
                s.cyc = 1'b0;
                s.stb = 1'b0;
            end
        endcase
    end

    // Terminations reach only the granted master; anything arriving in IDLE
    // or ABORT is dropped. A timeout is reported as err in its final cycle.
    always_comb begin
        m0.ack = 1'b0;
        m0.err = 1'b0;
        m1.ack = 1'b0;
        m1.err = 1'b0;
        case (state_q)
            GNT0: begin
                m0.ack = s.ack;
                m0.err = s.err || timeout_hit;
            end
            GNT1: begin
                m1.ack = s.ack;
                m1.err = s.err || timeout_hit;
            end
            default: begin
                m0.ack = 1'b0;
                m1.ack = 1'b0;
            end
        endcase
    end

    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_ddr_arbiter
//
// Directed bench for wb_ddr_arbiter. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge. The slave side is
// modelled directly by the stimulus (combinational ack in the chosen cycle).
// With WB_ARB_TIMEOUT_EN defined the DUT is built with timeout_cycles = 8 and
// the timeout scenario is included.
// ----------------------------------------------------------------------------
module tb_wb_ddr_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 1023;
`endif

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks   = 0;
    int   failures = 0;
    int   owner;

    wb_ddr_arbiter_if #(.adr_width(32)) m0_bus ();
    wb_ddr_arbiter_if #(.adr_width(32)) m1_bus ();
    wb_ddr_arbiter_if #(.adr_width(32)) s_bus ();

    always #5 clk_i = ~clk_i;

    wb_ddr_arbiter #(
        .adr_width     (32),
        .timeout_cycles(TIMEOUT)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus)
    );

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                                 input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
            m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
            m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
        end
    endtask

    task automatic slaveRespond(input logic ack, input logic err, input logic [31:0] dat);
        s_bus.ack   = ack;
        s_bus.err   = err;
        s_bus.dat_r = dat;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expAdr(input int k);
        return 32'h4000_0000 + 32'(4 * k);
    endfunction

    function automatic logic [31:0] expDat(input int k);
        return (((k % 2) == 1) ? 32'hB000_0000 : 32'hA000_0000) + 32'(k);
    endfunction

    function automatic logic [3:0] expSel(input int k);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << (k / 2);
        return ((k % 2) == 1) ? ~one_hot : one_hot;
    endfunction

    initial begin
        $display("[TB] start, timeout_cycles=%0d", TIMEOUT);
        rst_ni = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveRespond(1'b0, 1'b0, 32'h0);

        // ---------------- reset state ----------------
        nextCycle();
        nextCycle();
        m0_bus.adr = 32'h1234_5678;
        m1_bus.adr = 32'h8765_4321;
        slaveRespond(1'b1, 1'b1, 32'h0);
        settle();
        checkFlag("rst_s_cyc", s_bus.cyc, 1'b0);
        checkFlag("rst_s_stb", s_bus.stb, 1'b0);
        checkOutput("rst_s_adr_is_m0", s_bus.adr, 32'h1234_5678);
        checkFlag("rst_m0_ack", m0_bus.ack, 1'b0);
        checkFlag("rst_m1_ack", m1_bus.ack, 1'b0);
        checkFlag("rst_m0_err", m0_bus.err, 1'b0);
        checkFlag("rst_m1_err", m1_bus.err, 1'b0);

        nextCycle();
        rst_ni = 1'b1;
        settle();
        checkFlag("idle_ack_ignored", m0_bus.ack, 1'b0);
        checkFlag("idle_err_ignored", m1_bus.err, 1'b0);

        // ---------------- test 1: m0 single read ----------------
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        settle();
        checkFlag("t1_latency_s_cyc", s_bus.cyc, 1'b0);
        nextCycle();
        settle();
        checkFlag("t1_s_cyc", s_bus.cyc, 1'b1);
        checkFlag("t1_s_stb", s_bus.stb, 1'b1);
        checkOutput("t1_s_adr", s_bus.adr, 32'h0000_0100);
        checkFlag("t1_s_we", s_bus.we, 1'b0);
        checkFlag("t1_m0_ack_wait1", m0_bus.ack, 1'b0);
        checkFlag("t1_m1_ack_c1", m1_bus.ack, 1'b0);
        nextCycle();
        settle();
        checkFlag("t1_m0_ack_wait2", m0_bus.ack, 1'b0);
        checkFlag("t1_m1_ack_c2", m1_bus.ack, 1'b0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'hDEAD_BEEF);
        settle();
        checkFlag("t1_m0_ack", m0_bus.ack, 1'b1);
        checkOutput("t1_m0_dat", m0_bus.dat_r, 32'hDEAD_BEEF);
        checkOutput("t1_m1_dat", m1_bus.dat_r, 32'hDEAD_BEEF);
        checkFlag("t1_m1_ack_c3", m1_bus.ack, 1'b0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        checkFlag("t1_release_s_cyc", s_bus.cyc, 1'b0);
        checkFlag("t1_m0_ack_after", m0_bus.ack, 1'b0);

        // ---------------- test 2: simultaneous request after reset ----------------
        nextCycle();
        rst_ni = 1'b0;
        nextCycle();
        rst_ni = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222, 4'h3);
        settle();
        checkFlag("t2_latency_s_cyc", s_bus.cyc, 1'b0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("t2_first_adr_m0", s_bus.adr, 32'h0000_0010);
        checkOutput("t2_first_dat_m0", s_bus.dat_w, 32'h1111_1111);
        checkFlag("t2_m0_ack", m0_bus.ack, 1'b1);
        checkFlag("t2_m1_ack_waiting", m1_bus.ack, 1'b0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        checkFlag("t2_m0_release_s_cyc", s_bus.cyc, 1'b0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'h0);
        settle();
        checkFlag("t2_m1_no_bubble_s_cyc", s_bus.cyc, 1'b1);
        checkOutput("t2_second_adr_m1", s_bus.adr, 32'h0000_0020);
        checkOutput("t2_second_sel_m1", 32'(s_bus.sel), 32'h3);
        checkFlag("t2_m1_ack", m1_bus.ack, 1'b1);
        checkFlag("t2_m0_ack_idle", m0_bus.ack, 1'b0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        checkFlag("t2_m1_release_s_cyc", s_bus.cyc, 1'b0);

        // ---------------- test 3: strict alternation of single writes ----------------
        nextCycle();
        applyStimulus(0, 1'b1, 1'b1, 1'b1, expAdr(0), expDat(0), expSel(0));
        applyStimulus(1, 1'b1, 1'b1, 1'b1, expAdr(1), expDat(1), expSel(1));
        settle();
        checkFlag("t3_latency_s_cyc", s_bus.cyc, 1'b0);
        for (int k = 0; k < 8; k++) begin
            owner = k % 2;
            nextCycle();
            if (k + 1 < 8) begin
                applyStimulus(1 - owner, 1'b1, 1'b1, 1'b1, expAdr(k + 1), expDat(k + 1), expSel(k + 1));
            end
            slaveRespond(1'b1, 1'b0, 32'h0);
            settle();
            checkOutput($sformatf("t3_adr_%0d", k), s_bus.adr, expAdr(k));
            checkOutput($sformatf("t3_dat_%0d", k), s_bus.dat_w, expDat(k));
            checkOutput($sformatf("t3_sel_%0d", k), 32'(s_bus.sel), 32'(expSel(k)));
            checkFlag($sformatf("t3_we_%0d", k), s_bus.we, 1'b1);
            checkFlag($sformatf("t3_owner_ack_%0d", k), (owner == 0) ? m0_bus.ack : m1_bus.ack, 1'b1);
            checkFlag($sformatf("t3_other_ack_%0d", k), (owner == 0) ? m1_bus.ack : m0_bus.ack, 1'b0);
            nextCycle();
            applyStimulus(owner, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            slaveRespond(1'b0, 1'b0, 32'h0);
            settle();
            checkFlag($sformatf("t3_release_%0d", k), s_bus.cyc, 1'b0);
        end

        // ---------------- test 4: m1 burst is not preempted ----------------
        nextCycle();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        settle();
        checkFlag("t4_latency_s_cyc", s_bus.cyc, 1'b0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'h0000_1000);
        settle();
        checkOutput("t4_beat0_adr", s_bus.adr, 32'h0000_0200);
        checkFlag("t4_beat0_m1_ack", m1_bus.ack, 1'b1);
        checkOutput("t4_beat0_m1_dat", m1_bus.dat_r, 32'h0000_1000);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hF);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_5555, 4'hC);
        slaveRespond(1'b1, 1'b0, 32'h0000_1001);
        settle();
        checkOutput("t4_beat1_adr", s_bus.adr, 32'h0000_0204);
        checkFlag("t4_beat1_m1_ack", m1_bus.ack, 1'b1);
        checkFlag("t4_beat1_m0_ack", m0_bus.ack, 1'b0);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h0000_0208, 32'h0, 4'hF);
        slaveRespond(1'b0, 1'b0, 32'h0);
        settle();
        checkFlag("t4_gap_s_cyc", s_bus.cyc, 1'b1);
        checkFlag("t4_gap_s_stb", s_bus.stb, 1'b0);
        checkFlag("t4_gap_m0_ack", m0_bus.ack, 1'b0);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h0, 4'hF);
        slaveRespond(1'b1, 1'b0, 32'h0000_1002);
        settle();
        checkOutput("t4_beat2_adr", s_bus.adr, 32'h0000_0208);
        checkFlag("t4_beat2_m1_ack", m1_bus.ack, 1'b1);
        checkFlag("t4_beat2_m0_ack", m0_bus.ack, 1'b0);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_020C, 32'h0, 4'hF);
        slaveRespond(1'b1, 1'b0, 32'h0000_1003);
        settle();
        checkOutput("t4_beat3_adr", s_bus.adr, 32'h0000_020C);
        checkFlag("t4_beat3_m1_ack", m1_bus.ack, 1'b1);
        checkFlag("t4_beat3_m0_ack", m0_bus.ack, 1'b0);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveRespond(1'b0, 1'b0, 32'h0);
        settle();
        checkFlag("t4_m1_release_s_cyc", s_bus.cyc, 1'b0);
        checkFlag("t4_m1_release_m0_ack", m0_bus.ack, 1'b0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'h0);
        settle();
        checkFlag("t4_m0_granted_s_cyc", s_bus.cyc, 1'b1);
        checkOutput("t4_m0_adr", s_bus.adr, 32'h0000_0300);
        checkOutput("t4_m0_dat", s_bus.dat_w, 32'h0000_5555);
        checkOutput("t4_m0_sel", 32'(s_bus.sel), 32'hC);
        checkFlag("t4_m0_ack", m0_bus.ack, 1'b1);
        checkFlag("t4_m1_ack_after", m1_bus.ack, 1'b0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveRespond(1'b0, 1'b0, 32'h0);
        settle();
        checkFlag("t4_m0_release_s_cyc", s_bus.cyc, 1'b0);

        // ---------------- test 5: reset during stalled m1 read ----------------
        nextCycle();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
        settle();
        checkFlag("t5_latency_s_cyc", s_bus.cyc, 1'b0);
        nextCycle();
        settle();
        checkFlag("t5_m1_granted_s_cyc", s_bus.cyc, 1'b1);
        checkOutput("t5_m1_adr", s_bus.adr, 32'h0000_0600);
        nextCycle();
        rst_ni = 1'b0;
        settle();
        checkFlag("t5_reset_not_yet_sampled", s_bus.cyc, 1'b1);
        nextCycle();
        rst_ni = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveRespond(1'b1, 1'b0, 32'h0);
        settle();
        checkFlag("t5_after_reset_s_cyc", s_bus.cyc, 1'b0);
        checkFlag("t5_late_ack_m1", m1_bus.ack, 1'b0);
        checkFlag("t5_late_ack_m0", m0_bus.ack, 1'b0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
        settle();
        checkFlag("t5_both_latency_s_cyc", s_bus.cyc, 1'b0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("t5_m0_wins_adr", s_bus.adr, 32'h0000_0700);
        checkFlag("t5_m0_ack", m0_bus.ack, 1'b1);
        checkFlag("t5_m1_ack", m1_bus.ack, 1'b0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveRespond(1'b0, 1'b0, 32'h0);
        settle();
        checkFlag("t5_release_s_cyc", s_bus.cyc, 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
        // ---------------- test 6: stalled slave times out ----------------
        // m0 is the only requester, so it is granted regardless of history.
        nextCycle();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0, 4'hF);
        settle();
        checkFlag("t6_latency_s_cyc", s_bus.cyc, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            if (i == 2) begin
                applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'hF);
            end
            settle();
            checkFlag($sformatf("t6_stall%0d_s_cyc", i), s_bus.cyc, 1'b1);
            checkFlag($sformatf("t6_stall%0d_m0_err", i), m0_bus.err, (i == 8));
            checkFlag($sformatf("t6_stall%0d_m1_err", i), m1_bus.err, 1'b0);
        end
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'h0);
        settle();
        checkFlag("t6_abort_s_cyc", s_bus.cyc, 1'b0);
        checkFlag("t6_abort_s_stb", s_bus.stb, 1'b0);
        checkFlag("t6_abort_m0_err", m0_bus.err, 1'b0);
        checkFlag("t6_abort_late_ack", m0_bus.ack, 1'b0);
        checkFlag("t6_abort_m1_ack", m1_bus.ack, 1'b0);
        nextCycle();
        slaveRespond(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        checkFlag("t6_m0_drop_s_cyc", s_bus.cyc, 1'b0);
        nextCycle();
        slaveRespond(1'b1, 1'b0, 32'h0);
        settle();
        checkFlag("t6_m1_granted_s_cyc", s_bus.cyc, 1'b1);
        checkOutput("t6_m1_adr", s_bus.adr, 32'h0000_0A00);
        checkFlag("t6_m1_ack", m1_bus.ack, 1'b1);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slaveRespond(1'b0, 1'b0, 32'h0);
        settle();
        checkFlag("t6_release_s_cyc", s_bus.cyc, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
